// File: rtl/seq_div16_if.sv
// Request/result bundle for seq_div16; signedOp exists only when SIGNED_DIV_EN is defined.
// master = requester (drives start/operands), slave = divider (drives busy/done/results).
interface seq_div16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef SIGNED_DIV_EN
  logic             signedOp;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             divByZero;

`ifdef SIGNED_DIV_EN
  modport master (
    output start, dividend, divisor, signedOp,
    input  busy, done, quotient, remainder, divByZero
  );
  modport slave (
    input  start, dividend, divisor, signedOp,
    output busy, done, quotient, remainder, divByZero
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, divByZero
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, divByZero
  );
`endif
endinterface

// File: rtl/seq_div16.sv
// Restoring shift-subtract divider, one quotient bit per clock; done pulses WIDTH edges after acceptance
// (next cycle on divide-by-zero); start is ignored while busy. SIGNED_DIV_EN adds two's-complement mode.
module seq_div16 #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rstN,
  seq_div16_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH:0]   prem_q,   prem_d;
  logic [WIDTH-1:0] dvd_q,    dvd_d;
  logic [WIDTH-1:0] dsr_q,    dsr_d;
  logic [WIDTH-1:0] quot_q,   quot_d;
  logic [WIDTH-1:0] rmd_q,    rmd_d;
  logic             dbz_q,    dbz_d;
  logic             done_q,   done_d;
  logic             busy_q,   busy_d;
`ifdef SIGNED_DIV_EN
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             neg_a, neg_b;
`endif

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] res_quo, res_rem;

  // One restoring step: dvd_q shifts out dividend bits at the top and collects quotient bits at the bottom.
  always_comb begin
    shifted  = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    trial    = shifted - {1'b0, dsr_q};
    qbit     = ~trial[WIDTH];
    rem_next = qbit ? trial : shifted;
    quo_next = {dvd_q[WIDTH-2:0], qbit};
  end

  always_comb begin
`ifdef SIGNED_DIV_EN
    neg_a   = bus.signedOp & bus.dividend[WIDTH-1];
    neg_b   = bus.signedOp & bus.divisor[WIDTH-1];
    a_mag   = neg_a ? (-bus.dividend) : bus.dividend;
    b_mag   = neg_b ? (-bus.divisor)  : bus.divisor;
    res_quo = neg_quo_q ? (-quo_next) : quo_next;
    res_rem = neg_rem_q ? (-rem_next[WIDTH-1:0]) : rem_next[WIDTH-1:0];
`else
    a_mag   = bus.dividend;
    b_mag   = bus.divisor;
    res_quo = quo_next;
    res_rem = rem_next[WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quot_d  = quot_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
`ifdef SIGNED_DIV_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cnt_d  = '0;
          prem_d = '0;
          dvd_d  = a_mag;
          dsr_d  = b_mag;
          busy_d = 1'b1;
`ifdef SIGNED_DIV_EN
          neg_quo_d = neg_a ^ neg_b;
          neg_rem_d = neg_a;
`endif
          if (bus.divisor == '0) begin
            // Zero divisor short-circuits: results are written on the accepting edge itself.
            state_d = S_DONE;
            done_d  = 1'b1;
            quot_d  = '1;
            rmd_d   = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        prem_d = rem_next;
        dvd_d  = quo_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          quot_d  = res_quo;
          rmd_d   = res_rem;
          dbz_d   = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quot_q  <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef SIGNED_DIV_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rmd_q;
  assign bus.divByZero = dbz_q;

endmodule

// File: tb/tb_seq_div16.sv
// Scoreboard bench for seq_div16: stimulus pushes expected results, a negedge monitor pops on done.
module tb_seq_div16;
  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  seq_div16_if #(.WIDTH(16)) bus ();

  seq_div16 #(.WIDTH(16)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    int          cyc;
    int          tag;
  } exp_t;

  exp_t sb[$];
  exp_t em;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   tag    = 0;
  logic done_prev = 1'b0;
`ifdef SIGNED_DIV_EN
  logic sgn = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every done must match the oldest expected entry, in value and in cycle.
  always @(negedge clk) begin
    if (rstN) begin
      if (bus.done) begin
        chk("done_pulse_width", {31'd0, done_prev}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 required no pending operation (cycle %0d)", cyc);
        end else begin
          em = sb.pop_front();
          $display("op %0d: q=%0h r=%0h z=%0b", em.tag, bus.quotient, bus.remainder, bus.divByZero);
          chk("quotient",  {16'd0, bus.quotient},  {16'd0, em.q});
          chk("remainder", {16'd0, bus.remainder}, {16'd0, em.r});
          chk("divByZero", {31'd0, bus.divByZero}, {31'd0, em.z});
          chk("done_cycle", cyc, em.cyc);
          chk("busy_in_done", {31'd0, bus.busy}, 32'd1);
        end
      end
      done_prev = bus.done;
    end else begin
      done_prev = 1'b0;
    end
  end

  task automatic push(input logic [15:0] q, input logic [15:0] r, input logic z, input int c);
    tag++;
    sb.push_back('{q: q, r: r, z: z, cyc: c, tag: tag});
  endtask

  // Drives one start pulse from IDLE; lat is edges from acceptance to the done cycle.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input int lat,
                       input logic [15:0] q, input logic [15:0] r, input logic z);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
`ifdef SIGNED_DIV_EN
    bus.signedOp = sgn;
`endif
    push(q, r, z, cyc + 1 + lat);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL done_timeout: got %0d pending results required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_busy"},      {31'd0, bus.busy},      32'd0);
    chk({nm, "_done"},      {31'd0, bus.done},      32'd0);
    chk({nm, "_quotient"},  {16'd0, bus.quotient},  32'd0);
    chk({nm, "_remainder"}, {16'd0, bus.remainder}, 32'd0);
    chk({nm, "_divByZero"}, {31'd0, bus.divByZero}, 32'd0);
  endtask

  initial begin
    int a0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
`ifdef SIGNED_DIV_EN
    bus.signedOp = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rstN = 1'b1;

    issue(16'd100, 16'd7, 16, 16'd14, 16'd2, 1'b0);
    wait_idle();

    // start held high: second operand set is presented while busy and taken 18 edges later.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd65531;
    bus.divisor  = 16'd4;
    a0 = cyc + 1;
    push(16'd16382, 16'd3, 1'b0, a0 + 16);
    @(negedge clk);
    bus.dividend = 16'd65535;
    bus.divisor  = 16'd1;
    push(16'd65535, 16'd0, 1'b0, a0 + 18 + 16);
    repeat (18) @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    issue(16'd3, 16'd10, 16, 16'd0, 16'd3, 1'b0);
    wait_idle();
    issue(16'd0, 16'd5, 16, 16'd0, 16'd0, 1'b0);
    wait_idle();

    issue(16'd5, 16'd0, 0, 16'hFFFF, 16'd5, 1'b1);
    wait_idle();
    issue(16'd9, 16'd3, 16, 16'd3, 16'd0, 1'b0);
    wait_idle();

    // Abort at counter=8: issue returns just after the accepting edge.
    issue(16'd1000, 16'd3, 16, 16'd333, 16'd1, 1'b0);
    repeat (8) @(negedge clk);
    rstN = 1'b0;
    #1;
    chk_zero_outputs("abort");
    sb.delete();
    @(negedge clk);
    rstN = 1'b1;
    repeat (20) @(negedge clk);

    issue(16'd64, 16'd32, 16, 16'd2, 16'd0, 1'b0);
    repeat (5) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd7;
    bus.divisor  = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

`ifdef SIGNED_DIV_EN
    sgn = 1'b1;
    issue(16'hFF9C, 16'd7, 16, 16'hFFF2, 16'hFFFE, 1'b0);
    wait_idle();
    issue(16'd100, 16'hFFF9, 16, 16'hFFF2, 16'd2, 1'b0);
    wait_idle();
    issue(16'h8000, 16'hFFFF, 16, 16'h8000, 16'd0, 1'b0);
    wait_idle();
    issue(16'hFFFB, 16'd0, 0, 16'hFFFF, 16'hFFFB, 1'b1);
    wait_idle();
    sgn = 1'b0;
    issue(16'hFF9C, 16'd7, 16, 16'h2484, 16'd0, 1'b0);
    wait_idle();
`endif

    repeat (4) @(negedge clk);
    chk("pending_at_end", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
